// File: rtl/alu_share_arb.sv
// alu_share_arb: two clients time-share one combinational ALU through a single registered response slot.
// Define ALU_ARB_RR_EN for round-robin conflict priority; otherwise client 0 always wins conflicts.

module alu_share_alu (
  input  logic [4:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_o,
  output logic        flag_o
);
  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b01000;
  localparam logic [4:0] ALU_XOR  = 5'b00100;
  localparam logic [4:0] ALU_OR   = 5'b00110;
  localparam logic [4:0] ALU_AND  = 5'b00111;
  localparam logic [4:0] ALU_SRA  = 5'b01101;
  localparam logic [4:0] ALU_SRL  = 5'b00101;
  localparam logic [4:0] ALU_SLL  = 5'b00001;
  localparam logic [4:0] ALU_LTS  = 5'b11100;
  localparam logic [4:0] ALU_LTU  = 5'b11110;
  localparam logic [4:0] ALU_GES  = 5'b11101;
  localparam logic [4:0] ALU_GEU  = 5'b11111;
  localparam logic [4:0] ALU_EQ   = 5'b11000;
  localparam logic [4:0] ALU_NE   = 5'b11001;
  localparam logic [4:0] ALU_SLTS = 5'b00010;
  localparam logic [4:0] ALU_SLTU = 5'b00011;

  always_comb begin
    result_o = '0;
    flag_o   = 1'b0;
    case (op_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_AND:  result_o = a_i & b_i;
      ALU_SLL:  result_o = a_i << b_i;
      ALU_SRL:  result_o = a_i >> b_i;
      ALU_SRA:  result_o = $signed(a_i) >>> b_i;
      ALU_SLTS: result_o = {31'd0, $signed(a_i) < $signed(b_i)};
      ALU_SLTU: result_o = {31'd0, a_i < b_i};
      ALU_LTS:  flag_o = $signed(a_i) < $signed(b_i);
      ALU_LTU:  flag_o = a_i < b_i;
      ALU_GES:  flag_o = $signed(a_i) >= $signed(b_i);
      ALU_GEU:  flag_o = a_i >= b_i;
      ALU_EQ:   flag_o = a_i == b_i;
      ALU_NE:   flag_o = a_i != b_i;
      default:  result_o = '0;
    endcase
    // Branch compares all live in the 11xxx code space and mirror the flag onto the result.
    if (op_i[4:3] == 2'b11) result_o = {31'd0, flag_o};
  end
endmodule

module alu_share_arb (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [1:0]  req_valid_i,
  output logic [1:0]  req_ready_o,
  input  logic [4:0]  req_op0_i,
  input  logic [4:0]  req_op1_i,
  input  logic [31:0] req_a0_i,
  input  logic [31:0] req_a1_i,
  input  logic [31:0] req_b0_i,
  input  logic [31:0] req_b1_i,
  output logic [1:0]  rsp_valid_o,
  input  logic [1:0]  rsp_ready_i,
  output logic [31:0] rsp_result_o,
  output logic        rsp_flag_o
);
  // state   | meaning
  // S_EMPTY | no response held, any client may be granted
  // S_FULL  | response held for owner_q until its rsp_ready_i
  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic [31:0] result_q, result_d;
  logic        flag_q, flag_d;
  logic        prio;
  logic        slot_free, grant_vld, grant_idx, accept;
  logic [4:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_flag;

`ifdef ALU_ARB_RR_EN
  logic prio_q, prio_d;
  assign prio = prio_q;
`else
  assign prio = 1'b0;
`endif

  always_comb begin
    slot_free = (state_q == S_EMPTY) || rsp_ready_i[owner_q];
    grant_vld = |req_valid_i;
    case (req_valid_i)
      2'b11:   grant_idx = prio;
      2'b10:   grant_idx = 1'b1;
      default: grant_idx = 1'b0;
    endcase
    req_ready_o = 2'b00;
    if (rst_n_i && slot_free && grant_vld) req_ready_o[grant_idx] = 1'b1;
    accept = |(req_valid_i & req_ready_o);
  end

  assign alu_op = grant_idx ? req_op1_i : req_op0_i;
  assign alu_a  = grant_idx ? req_a1_i  : req_a0_i;
  assign alu_b  = grant_idx ? req_b1_i  : req_b0_i;

  alu_share_alu u_alu (
    .op_i     (alu_op),
    .a_i      (alu_a),
    .b_i      (alu_b),
    .result_o (alu_result),
    .flag_o   (alu_flag)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    result_d = result_q;
    flag_d   = flag_q;
    if (accept) begin
      state_d  = S_FULL;
      owner_d  = grant_idx;
      result_d = alu_result;
      flag_d   = alu_flag;
    end else if (state_q == S_FULL && rsp_ready_i[owner_q]) begin
      state_d = S_EMPTY;
    end
  end

`ifdef ALU_ARB_RR_EN
  assign prio_d = accept ? ~grant_idx : prio_q;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_EMPTY;
      owner_q  <= 1'b0;
      result_q <= '0;
      flag_q   <= 1'b0;
`ifdef ALU_ARB_RR_EN
      prio_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      result_q <= result_d;
      flag_q   <= flag_d;
`ifdef ALU_ARB_RR_EN
      prio_q   <= prio_d;
`endif
    end
  end

  assign rsp_valid_o  = (state_q == S_FULL) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_result_o = result_q;
  assign rsp_flag_o   = flag_q;
endmodule

// File: tb/tb_alu_share_arb.sv
// Testbench for alu_share_arb: directed scenarios plus random traffic, checked by a queue scoreboard.
`timescale 1ns/1ps
module tb_alu_share_arb;
  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b01000;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_AND  = 5'b00111;
  localparam logic [4:0] OP_SRA  = 5'b01101;
  localparam logic [4:0] OP_SRL  = 5'b00101;
  localparam logic [4:0] OP_SLL  = 5'b00001;
  localparam logic [4:0] OP_LTS  = 5'b11100;
  localparam logic [4:0] OP_LTU  = 5'b11110;
  localparam logic [4:0] OP_GES  = 5'b11101;
  localparam logic [4:0] OP_GEU  = 5'b11111;
  localparam logic [4:0] OP_EQ   = 5'b11000;
  localparam logic [4:0] OP_NE   = 5'b11001;
  localparam logic [4:0] OP_SLTS = 5'b00010;
  localparam logic [4:0] OP_SLTU = 5'b00011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [4:0]  op0, op1;
  logic [31:0] a0, a1, b0, b1, rsp_result;
  logic        rsp_flag;

  typedef struct packed {logic [31:0] r; logic f;} exp_t;
  exp_t        q0[$];
  exp_t        q1[$];
  int          grant_log[$];
  logic        m_prio;
  logic [1:0]  fired;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [4:0]  ops[16];

  always #5 clk = ~clk;

  alu_share_arb dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_op0_i    (op0),
    .req_op1_i    (op1),
    .req_a0_i     (a0),
    .req_a1_i     (a1),
    .req_b0_i     (b0),
    .req_b1_i     (b1),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_result_o (rsp_result),
    .rsp_flag_o   (rsp_flag)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU from the op definitions, using 64-bit signed arithmetic.
  function automatic exp_t ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb;
    bit     br;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.r = 32'd0;
    e.f = 1'b0;
    br = 1'b0;
    case (op)
      OP_ADD:  e.r = a + b;
      OP_SUB:  e.r = a - b;
      OP_XOR:  e.r = a ^ b;
      OP_OR:   e.r = a | b;
      OP_AND:  e.r = a & b;
      OP_SLL:  e.r = (b > 32'd31) ? 32'd0 : (a << b[4:0]);
      OP_SRL:  e.r = (b > 32'd31) ? 32'd0 : (a >> b[4:0]);
      OP_SRA:  e.r = (b > 32'd31) ? (a[31] ? 32'hFFFF_FFFF : 32'd0) : 32'(sa >>> b[4:0]);
      OP_SLTS: e.r = (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU: e.r = (a < b) ? 32'd1 : 32'd0;
      OP_LTS:  begin e.f = (sa < sb);  br = 1'b1; end
      OP_LTU:  begin e.f = (a < b);    br = 1'b1; end
      OP_GES:  begin e.f = (sa >= sb); br = 1'b1; end
      OP_GEU:  begin e.f = (a >= b);   br = 1'b1; end
      OP_EQ:   begin e.f = (a == b);   br = 1'b1; end
      OP_NE:   begin e.f = (a != b);   br = 1'b1; end
      default: e.r = 32'd0;
    endcase
    if (br) e.r = e.f ? 32'd1 : 32'd0;
    return e;
  endfunction

  // Monitor: models the slot as per-client expected-response queues and checks every cycle.
  always @(negedge clk) begin : mon
    logic       full, owner, drain, free, win;
    logic [1:0] exp_ready;
    exp_t       e;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      m_prio = 1'b0;
      fired = 2'b00;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_result", rsp_result, 0);
    end else begin
      full  = (q0.size() + q1.size()) != 0;
      owner = q1.size() != 0;
      chk("rsp_valid", rsp_valid, {q1.size() != 0, q0.size() != 0});
      drain = full && rsp_ready[owner];
      free  = !full || drain;
      exp_ready = 2'b00;
      if (free && req_valid != 2'b00) begin
        win = (req_valid == 2'b11) ? m_prio : req_valid[1];
        exp_ready[win] = 1'b1;
      end
      chk("req_ready", req_ready, exp_ready);
      if (drain) begin
        e = owner ? q1.pop_front() : q0.pop_front();
        chk("rsp_result", rsp_result, e.r);
        chk("rsp_flag", rsp_flag, e.f);
      end
      fired = req_valid & req_ready;
      if (fired[0]) begin q0.push_back(ref_alu(op0, a0, b0)); grant_log.push_back(0); end
      if (fired[1]) begin q1.push_back(ref_alu(op1, a1, b1)); grant_log.push_back(1); end
`ifdef ALU_ARB_RR_EN
      if (fired[0]) m_prio = 1'b1;
      else if (fired[1]) m_prio = 1'b0;
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    req_valid = 2'b00;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic rand_req(input int k);
    logic [31:0] a, b;
    logic [4:0]  op;
    op = ops[$urandom_range(0, 15)];
    a  = $urandom;
    b  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
    req_valid[k] = ($urandom_range(0, 3) != 0);
    if (k == 0) begin op0 = op; a0 = a; b0 = b; end
    else        begin op1 = op; a1 = a; b1 = b; end
  endtask

  initial begin
    ops = '{OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND, OP_SRA, OP_SRL, OP_SLL,
            OP_LTS, OP_LTU, OP_GES, OP_GEU, OP_EQ, OP_NE, OP_SLTS, OP_SLTU};
    req_valid = 2'b00; rsp_ready = 2'b00; fired = 2'b00; m_prio = 1'b0;
    op0 = OP_ADD; op1 = OP_ADD; a0 = 0; a1 = 0; b0 = 0; b1 = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Continuous contention straight out of reset.
    rsp_ready = 2'b11;
    op0 = OP_ADD; a0 = 10; b0 = 1;
    op1 = OP_SUB; a1 = 10; b1 = 1;
    req_valid = 2'b11;
    grant_log.delete();
    repeat (4) step();
    req_valid = 2'b00;
    step();
    chk("grant_cnt", grant_log.size(), 4);
    for (int i = 0; i < grant_log.size() && i < 4; i++) begin
`ifdef ALU_ARB_RR_EN
      chk("grant_seq", grant_log[i], i % 2);
`else
      chk("grant_seq", grant_log[i], 0);
`endif
    end

    reset_pulse();

    // Single ADD after reset: latency one cycle.
    op0 = OP_ADD; a0 = 32'h0000_0005; b0 = 32'h0000_0003; req_valid = 2'b01; rsp_ready = 2'b11;
    @(negedge clk); chk("t1_req_ready", req_ready, 2'b01);
    step(); req_valid = 2'b00;
    @(negedge clk);
    chk("t1_rsp_valid", rsp_valid, 2'b01);
    chk("t1_result", rsp_result, 8);
    chk("t1_flag", rsp_flag, 0);
    step();

    // Held response blocks both clients until drained.
    op1 = OP_SUB; a1 = 0; b1 = 1; req_valid = 2'b10; rsp_ready = 2'b01;
    step();
    op0 = OP_ADD; a0 = 1; b0 = 1; req_valid = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_hold_valid", rsp_valid, 2'b10);
      chk("t2_hold_result", rsp_result, 32'hFFFF_FFFF);
      chk("t2_blocked", req_ready, 2'b00);
      step();
    end
    rsp_ready = 2'b11;
    @(negedge clk); chk("t2_drain_accept", req_ready, 2'b01);
    step(); req_valid = 2'b00;
    @(negedge clk);
    chk("t2_next_valid", rsp_valid, 2'b01);
    chk("t2_next_result", rsp_result, 2);
    step();

    // Branch compares from client 1.
    op1 = OP_EQ; a1 = 32'h1234_5678; b1 = 32'h1234_5678; req_valid = 2'b10;
    step();
    op1 = OP_LTU; a1 = 2; b1 = 1;
    @(negedge clk);
    chk("t4_eq_result", rsp_result, 1);
    chk("t4_eq_flag", rsp_flag, 1);
    step(); req_valid = 2'b00;
    @(negedge clk);
    chk("t4_ltu_valid", rsp_valid, 2'b10);
    chk("t4_ltu_result", rsp_result, 0);
    chk("t4_ltu_flag", rsp_flag, 0);
    step();

    // Back-to-back ADDs: no bubbles.
    op0 = OP_ADD; a0 = 1000; b0 = 1; req_valid = 2'b01;
    step();
    for (int i = 1; i <= 4; i++) begin
      a0 = 32'(1000 + i);
      if (i == 4) req_valid = 2'b00;
      @(negedge clk);
      chk("t5_b2b_valid", rsp_valid, 2'b01);
      chk("t5_b2b_result", rsp_result, 32'(1000 + i));
      step();
    end

    // Asynchronous reset while a response is held.
    rsp_ready = 2'b00; op0 = OP_XOR; a0 = 32'hF0F0_0000; b0 = 32'h0000_0F0F; req_valid = 2'b01;
    step(); req_valid = 2'b00;
    @(negedge clk); chk("t6_full", rsp_valid, 2'b01);
    @(posedge clk);
    #3;
    req_valid = 2'b11; rsp_ready = 2'b11; rst_n = 1'b0;
    #1;
    chk("t6_async_valid", rsp_valid, 0);
    chk("t6_async_result", rsp_result, 0);
    chk("t6_async_flag", rsp_flag, 0);
    chk("t6_async_ready", req_ready, 0);
    req_valid = 2'b00;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("t6_idle", rsp_valid, 0);
      step();
    end

    // Random traffic; a stalled requester keeps its operands stable.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int k = 0; k < 2; k++)
        if (!req_valid[k] || fired[k]) rand_req(k);
      rsp_ready[0] = ($urandom_range(0, 3) != 0);
      rsp_ready[1] = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    repeat (3) step();
    chk("final_empty", q0.size() + q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
